csa_resolve_seq: RTL
====================

// Module: csa_resolve_seq
// PURPOSE
//  Sequential carry-propagate converter for the Dadda multiplier back end.
//  Takes the redundant sum/carry vector pair left by the compressor tree and
//  resolves it to a plain binary result, CHUNK bits per clock, carry held in a flop.
//  Sits between the reduction tree output register and the product consumer.
//  Valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  16  bits in each of in_sum/in_carry; result is WIDTH+1 bits
//  CHUNK   4  bits resolved per cycle; WIDTH % CHUNK == 0; N = WIDTH/CHUNK
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  in_valid    in   1        operand pair valid
//  in_ready    out  1        block can accept operands (state IDLE)
//  in_sum      in   WIDTH    sum vector
//  in_carry    in   WIDTH    carry vector, already weight-aligned to in_sum
//  out_valid   out  1        out_result valid (state DONE)
//  out_ready   in   1        consumer accepts result
//  out_result  out  WIDTH+1  in_sum + in_carry; bit WIDTH = final carry-out
//  busy        out  1        high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, idx=0, cy=0, result reg=0.
//    out_valid=0, out_result=0, busy=0, in_ready=1. An in-flight op is discarded.
//  - FSM:
//    IDLE: in_ready=1. On in_valid & in_ready at an edge: latch in_sum/in_carry,
//      clear result reg, cy=0, idx=0 -> RUN. in_valid without acceptance is ignored.
//    RUN: each edge computes {c,r} = sum[idx] + carry[idx] + cy over CHUNK-bit chunk
//      idx, then result[idx]=r, cy=c, idx++. After chunk N-1: result[WIDTH]=c -> DONE.
//      in_ready=0. Inputs are not sampled.
//    DONE: out_valid=1. out_result is held stable until out_valid & out_ready at an
//      edge, then -> IDLE. in_ready=0 in DONE (no overlap of operations).
//  - Latency: out_valid rises N edges after the accepting edge.
//    in_ready returns the cycle after the output handshake.
//    Throughput is one op per N+2 cycles with out_ready held high.
//  - Arithmetic: unsigned; WIDTH+1-bit result never overflows.
//  - out_result equals the result register; it is 0 except while in DONE.
//    It is not driven from partial RUN values.
//  - idx is log2(N) bits, wide enough to count to N-1 without wrap. It resets to 0
//    on accept.
// CONFIGURATION
//  CSA_EARLY_EXIT_EN defined:
//   - In RUN, after chunk k is computed, go to DONE on that same edge when all of:
//     chunk carry-out c == 0, and in_sum/in_carry chunks k+1..N-1 are all zero.
//   - Upper result bits stay 0. Latency becomes k+1 edges; results are bit-identical.
//  CSA_EARLY_EXIT_EN undefined: always exactly N RUN cycles; no zero-detect logic.
// TESTING  (WIDTH=16, CHUNK=4, N=4)
//  1. Ripple: sum=0x00FF, carry=0x0001.
//     -> result 0x00100; out_valid at edge 4 without the macro, edge 3 with it.
//  2. Max: sum=0xFFFF, carry=0xFFFF.
//     -> result 0x1FFFE (bit16=1); out_valid at edge 4 in both builds.
//  3. Backpressure: out_ready=0 for 3 cycles in DONE, in_valid=1 throughout.
//     -> result and out_valid stable, in_ready=0, no second op accepted.
//  4. Reset mid-RUN: rst_n=0 after edge 2 of an op.
//     -> out_valid=0 and busy=0 immediately (async), in_ready=1.
//     Next op sum=0x1234, carry=0x0101 -> 0x01335.
//  5. Back-to-back: out_ready=1, in_valid=1 continuously, two ops.
//     -> 2nd accept occurs the cycle after 1st out handshake; both results correct.
//  6. Early exit: sum=0x0003, carry=0x0001.
//     -> result 0x00004; out_valid at edge 1 with the macro, edge 4 without it.

Source files
------------

// File: rtl/csa_resolve_seq.sv
// Sequential carry-propagate resolver: adds a sum/carry vector pair CHUNK bits per clock.
// Optional early termination is enabled by defining CSA_EARLY_EXIT_EN.
module csa_resolve_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cy_q, cy_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   carry_q, carry_d;
    logic [WIDTH:0]     result_q, result_d;
    logic [CHUNK:0]     chunk_res;
    logic               last_chunk;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and outputs stay stable while valid is high without ready.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_result  = out_valid ? result_q : '0;
    assign dbg_state_o = state_q;

    assign chunk_res  = {1'b0, sum_q[idx_q*CHUNK +: CHUNK]}
                      + {1'b0, carry_q[idx_q*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, cy_q};
    assign last_chunk = (idx_q == IDX_W'(N - 1));

`ifdef CSA_EARLY_EXIT_EN
    logic [N-1:0] chunk_nz;
    logic         upper_zero;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            chunk_nz[j] = |(sum_q[j*CHUNK +: CHUNK] | carry_q[j*CHUNK +: CHUNK]);
        end
    end

    // True when every operand chunk above the one being resolved is zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < N; j++) begin
            if ((j > int'(idx_q)) && chunk_nz[j]) begin
                upper_zero = 1'b0;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sum_d    = in_sum;
                    carry_d  = in_carry;
                    result_d = '0;
                    cy_d     = 1'b0;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                cy_d  = chunk_res[CHUNK];
                idx_d = idx_q + 1'b1;
                if (last_chunk) begin
                    result_d[WIDTH] = chunk_res[CHUNK];
                    state_d         = S_DONE;
                end
`ifdef CSA_EARLY_EXIT_EN
                else if (!chunk_res[CHUNK] && upper_zero) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    result_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

endmodule
